// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART receive FIFO.
package uart_pkg;

  localparam int unsigned DATA_BITS_DEF = 8;
  localparam int unsigned DEPTH_DEF     = 16;

  typedef struct packed {
    logic [DATA_BITS_DEF-1:0] data;
    logic                     parity_err;
    logic                     frame_err;
  } fifo_entry_t;

  // Flag bits appended below the character in every stored entry.
  localparam int unsigned FLAG_BITS = $bits(fifo_entry_t) - DATA_BITS_DEF;

endpackage

// File: rtl/uart_fifo_mem.sv
// Dual-port register array: synchronous write, asynchronous read.
module uart_fifo_mem #(
  parameter int unsigned WIDTH = 10,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [WIDTH-1:0]         rd_data
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through FIFO behind a UART receiver, with sticky overflow.
// Define UART_RX_FIFO_DROP_ERR_EN to discard characters that carry a framing error.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS   = DATA_BITS_DEF,
  parameter int unsigned DEPTH       = DEPTH_DEF,
  parameter int unsigned AFULL_LEVEL = 12
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [DATA_BITS-1:0]   rx_data,
  input  logic                   data_ready,
  input  logic                   parity_err,
  input  logic                   frame_err,
  output logic [DATA_BITS-1:0]   rd_data,
  output logic                   rd_valid,
  input  logic                   rd_ready,
  output logic                   rd_parity_err,
  output logic                   rd_frame_err,
  output logic [$clog2(DEPTH):0] count,
  output logic                   almost_full,
  output logic                   overflow,
  input  logic                   clr_overflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam int unsigned EW = DATA_BITS + FLAG_BITS;

  logic          dr_prev_q;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic          overflow_q, overflow_d;
  logic [EW-1:0] wr_entry, rd_entry;
  logic          wr_edge, wr_req, wr_en, rd_en, ovf_evt;
  logic          empty, full;

  // Pointers carry an extra wrap bit so full and empty are distinguishable.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  always_comb begin
    wr_edge = data_ready & ~dr_prev_q;
`ifdef UART_RX_FIFO_DROP_ERR_EN
    wr_req  = wr_edge & ~frame_err;
`else
    wr_req  = wr_edge;
`endif
    rd_en      = ~empty & rd_ready;
    // A read in the same cycle frees the slot, so a full FIFO still accepts.
    wr_en      = wr_req & (~full | rd_en);
    ovf_evt    = wr_req & full & ~rd_en;
    wr_ptr_d   = wr_ptr_q + PW'(wr_en);
    rd_ptr_d   = rd_ptr_q + PW'(rd_en);
    overflow_d = ovf_evt | (overflow_q & ~clr_overflow);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dr_prev_q  <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      dr_prev_q  <= data_ready;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      overflow_q <= overflow_d;
    end
  end

  assign wr_entry = {rx_data, parity_err, frame_err};

  uart_fifo_mem #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr_q[AW-1:0]),
    .wr_data (wr_entry),
    .rd_addr (rd_ptr_q[AW-1:0]),
    .rd_data (rd_entry)
  );

  // Head fields are masked while empty so stale storage never shows.
  assign rd_valid      = ~empty;
  assign rd_data       = rd_valid ? rd_entry[EW-1:FLAG_BITS] : '0;
  assign rd_parity_err = rd_valid & rd_entry[1];
`ifdef UART_RX_FIFO_DROP_ERR_EN
  logic unused_frame_err;
  assign unused_frame_err = rd_entry[0];
  assign rd_frame_err     = 1'b0;
`else
  assign rd_frame_err  = rd_valid & rd_entry[0];
`endif
  assign count       = wr_ptr_q - rd_ptr_q;
  assign almost_full = (count >= PW'(AFULL_LEVEL));
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed self-checking bench for uart_rx_fifo (table vectors plus corner sequences).
module tb_uart_rx_fifo;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] rx_data;
  logic       data_ready;
  logic       parity_err;
  logic       frame_err;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       rd_ready;
  logic       rd_parity_err;
  logic       rd_frame_err;
  logic [4:0] count;
  logic       almost_full;
  logic       overflow;
  logic       clr_overflow;

  int n_checks = 0;
  int n_errors = 0;

  uart_rx_fifo #(
    .DATA_BITS   (8),
    .DEPTH       (16),
    .AFULL_LEVEL (12)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .rx_data       (rx_data),
    .data_ready    (data_ready),
    .parity_err    (parity_err),
    .frame_err     (frame_err),
    .rd_data       (rd_data),
    .rd_valid      (rd_valid),
    .rd_ready      (rd_ready),
    .rd_parity_err (rd_parity_err),
    .rd_frame_err  (rd_frame_err),
    .count         (count),
    .almost_full   (almost_full),
    .overflow      (overflow),
    .clr_overflow  (clr_overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic [7:0] rx;
    logic       pe;
    logic       fe;
    logic       exp_valid;
    logic [7:0] exp_data;
    logic       exp_pe;
    logic       exp_fe;
    logic [4:0] exp_count;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset        = 1'b1;
    rx_data      = '0;
    data_ready   = 1'b0;
    parity_err   = 1'b0;
    frame_err    = 1'b0;
    rd_ready     = 1'b0;
    clr_overflow = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic write_byte(input logic [7:0] b, input logic pe, input logic fe, input int hold);
    rx_data    = b;
    parity_err = pe;
    frame_err  = fe;
    data_ready = 1'b1;
    repeat (hold) tick();
    data_ready = 1'b0;
    parity_err = 1'b0;
    frame_err  = 1'b0;
    tick();
  endtask

  task automatic read_one();
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
  endtask

  task automatic fill(input logic [7:0] base, input int n);
    for (int i = 0; i < n; i++) write_byte(base + 8'(i), 1'b0, 1'b0, 2);
  endtask

  logic [7:0] model_q[$];
  logic [7:0] b;

  initial begin
    vecs[0] = '{8'h41, 1'b0, 1'b0, 1'b1, 8'h41, 1'b0, 1'b0, 5'd1};
    vecs[1] = '{8'h7E, 1'b1, 1'b0, 1'b1, 8'h7E, 1'b1, 1'b0, 5'd1};
    vecs[3] = '{8'hA5, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0, 5'd1};
`ifdef UART_RX_FIFO_DROP_ERR_EN
    vecs[2] = '{8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 5'd0};
    vecs[4] = '{8'hFF, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 5'd0};
`else
    vecs[2] = '{8'h00, 1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 1'b1, 5'd1};
    vecs[4] = '{8'hFF, 1'b1, 1'b1, 1'b1, 8'hFF, 1'b1, 1'b1, 5'd1};
`endif

    // Reset state
    do_reset();
    check("rst_rd_valid", 32'(rd_valid), 0);
    check("rst_count", 32'(count), 0);
    check("rst_almost_full", 32'(almost_full), 0);
    check("rst_overflow", 32'(overflow), 0);
    check("rst_rd_data", 32'(rd_data), 0);
    check("rst_rd_pe", 32'(rd_parity_err), 0);
    check("rst_rd_fe", 32'(rd_frame_err), 0);

    // Long data_ready level yields exactly one write, visible the next cycle
    rx_data    = 8'h41;
    data_ready = 1'b1;
    tick();
    check("pulse_rd_valid", 32'(rd_valid), 1);
    check("pulse_rd_data", 32'(rd_data), 32'h41);
    check("pulse_count", 32'(count), 1);
    repeat (15) tick();
    data_ready = 1'b0;
    tick();
    check("pulse_single_write", 32'(count), 1);
    read_one();
    check("pulse_drained", 32'(count), 0);
    check("pulse_empty", 32'(rd_valid), 0);

    // Table vectors: data and error flags through an empty FIFO
    for (int i = 0; i < 5; i++) begin
      write_byte(vecs[i].rx, vecs[i].pe, vecs[i].fe, 3);
      check($sformatf("vec%0d_valid", i), 32'(rd_valid), 32'(vecs[i].exp_valid));
      check($sformatf("vec%0d_data", i), 32'(rd_data), 32'(vecs[i].exp_data));
      check($sformatf("vec%0d_pe", i), 32'(rd_parity_err), 32'(vecs[i].exp_pe));
      check($sformatf("vec%0d_fe", i), 32'(rd_frame_err), 32'(vecs[i].exp_fe));
      check($sformatf("vec%0d_count", i), 32'(count), 32'(vecs[i].exp_count));
      check($sformatf("vec%0d_overflow", i), 32'(overflow), 0);
      read_one();
      check($sformatf("vec%0d_after_read", i), 32'(count), 0);
    end

    // Overflow: 17th byte dropped, order preserved
    do_reset();
    fill(8'h00, 11);
    check("af_below", 32'(almost_full), 0);
    fill(8'h0B, 1);
    check("af_at_level", 32'(almost_full), 1);
    fill(8'h0C, 4);
    check("full_count", 32'(count), 16);
    check("full_no_ovf", 32'(overflow), 0);
    write_byte(8'hAA, 1'b0, 1'b0, 2);
    check("ovf_set", 32'(overflow), 1);
    check("ovf_count", 32'(count), 16);
    for (int i = 0; i < 16; i++) begin
      check($sformatf("ovf_drain%0d", i), 32'(rd_data), 32'(i));
      read_one();
    end
    check("ovf_drain_empty", 32'(rd_valid), 0);
    check("ovf_drain_count", 32'(count), 0);
    check("ovf_sticky", 32'(overflow), 1);
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
    check("read_empty_count", 32'(count), 0);
    clr_overflow = 1'b1;
    tick();
    clr_overflow = 1'b0;
    check("ovf_cleared", 32'(overflow), 0);

    // Simultaneous write and read while full
    do_reset();
    fill(8'h10, 16);
    rx_data    = 8'h55;
    data_ready = 1'b1;
    rd_ready   = 1'b1;
    tick();
    data_ready = 1'b0;
    rd_ready   = 1'b0;
    check("fullrw_overflow", 32'(overflow), 0);
    check("fullrw_count", 32'(count), 16);
    check("fullrw_head", 32'(rd_data), 32'h11);
    tick();
    for (int i = 0; i < 15; i++) begin
      check($sformatf("fullrw_drain%0d", i), 32'(rd_data), 32'(8'h11 + i));
      read_one();
    end
    check("fullrw_last", 32'(rd_data), 32'h55);
    read_one();
    check("fullrw_empty", 32'(rd_valid), 0);

    // Interleaved traffic at occupancy 3, wrapping the pointers twice
    do_reset();
    model_q.delete();
    for (int i = 0; i < 3; i++) begin
      b = 8'h80 + 8'(i);
      write_byte(b, 1'b0, 1'b0, 1);
      model_q.push_back(b);
    end
    for (int i = 0; i < 40; i++) begin
      b = 8'h20 + 8'(i);
      check($sformatf("wrap_head%0d", i), 32'(rd_data), 32'(model_q[0]));
      rx_data    = b;
      data_ready = 1'b1;
      rd_ready   = 1'b1;
      tick();
      void'(model_q.pop_front());
      model_q.push_back(b);
      data_ready = 1'b0;
      rd_ready   = 1'b0;
      check($sformatf("wrap_count%0d", i), 32'(count), 3);
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      check($sformatf("wrap_tail%0d", i), 32'(rd_data), 32'(model_q[0]));
      void'(model_q.pop_front());
      read_one();
    end
    check("wrap_empty", 32'(rd_valid), 0);

    // Set wins over clear; then reset mid-operation
    do_reset();
    fill(8'h30, 16);
    rx_data      = 8'hEE;
    data_ready   = 1'b1;
    clr_overflow = 1'b1;
    tick();
    data_ready   = 1'b0;
    clr_overflow = 1'b0;
    check("set_wins", 32'(overflow), 1);
    tick();
    check("set_wins_count", 32'(count), 16);
    clr_overflow = 1'b1;
    tick();
    clr_overflow = 1'b0;
    check("clr_alone", 32'(overflow), 0);
    write_byte(8'hEF, 1'b0, 1'b0, 2);
    check("ovf_again", 32'(overflow), 1);
    repeat (11) read_one();
    check("pre_reset_count", 32'(count), 5);
    rx_data    = 8'h66;
    data_ready = 1'b1;
    reset      = 1'b1;
    #1;
    check("midrst_count", 32'(count), 0);
    check("midrst_valid", 32'(rd_valid), 0);
    check("midrst_overflow", 32'(overflow), 0);
    check("midrst_af", 32'(almost_full), 0);
    tick();
    reset = 1'b0;
    check("midrst_held_count", 32'(count), 0);
    tick();
    data_ready = 1'b0;
    check("post_rst_write_count", 32'(count), 1);
    check("post_rst_write_data", 32'(rd_data), 32'h66);
    tick();
    check("post_rst_no_repeat", 32'(count), 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
